// File: rtl/psum_bank_acc.sv
// rtl/psum_bank_acc.sv - multi-bank partial-sum accumulation buffer with in-order drain
module psum_bank_acc #(
  parameter int DWIDTH    = 32,
  parameter int PE_DWIDTH = 16,
  parameter int AWIDTH    = 4,
  parameter int NBANK     = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [AWIDTH-1:0]        cfg_len_m1,
  input  logic                     cfg_sat,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PE_DWIDTH-1:0]     in_data,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_sat,
  output logic                     out_last,
  output logic [$clog2(NBANK)-1:0] out_bank,
  output logic                     busy
);
  localparam int BW    = $clog2(NBANK);
  localparam int DEPTH = 2**AWIDTH;

  typedef enum logic [1:0] {B_FREE, B_ACC, B_DRAIN} bank_st_e;

  bank_st_e          bank_st_q  [NBANK];
  bank_st_e          bank_st_d  [NBANK];
  logic [AWIDTH-1:0] bank_len_q [NBANK];
  logic [AWIDTH-1:0] bank_len_d [NBANK];
  logic [DWIDTH-1:0] mem_q      [NBANK][DEPTH];
  logic              flag_q     [NBANK][DEPTH];

  logic [BW-1:0]     acc_bank_q, acc_bank_d;
  logic [AWIDTH-1:0] idx_q, idx_d, len_q, len_d, p_len;
  logic              sat_q, sat_d, first_q, first_d, last_q, last_d, rdy_en_q;
  logic              at_idx0, p_sat, p_first, p_last, pass_end, accept, start_tile;

  logic                 s1_valid_q, s1_valid_d, s1_sat_q, s1_sat_d;
  logic                 s1_first_q, s1_first_d, s1_fin_q, s1_fin_d;
  logic [BW-1:0]        s1_bank_q, s1_bank_d;
  logic [AWIDTH-1:0]    s1_idx_q, s1_idx_d;
  logic [PE_DWIDTH-1:0] s1_data_q, s1_data_d;
  logic [DWIDTH-1:0]    rd_data_q, rd_data_d;
  logic                 rd_flag_q, rd_flag_d;

  logic              s2_valid_q, s2_valid_d, s2_flag_q, s2_flag_d;
  logic [BW-1:0]     s2_bank_q, s2_bank_d;
  logic [AWIDTH-1:0] s2_idx_q, s2_idx_d;
  logic [DWIDTH-1:0] s2_sum_q, s2_sum_d;
  logic              fwd, ovf, sat_now, old_flag, flag_new;
  logic [DWIDTH-1:0] old_val, ext_val, sum_val;
  logic [DWIDTH:0]   wide;

  logic [BW-1:0]     drain_bank_q, drain_bank_d, out_bank_q, out_bank_d;
  logic [AWIDTH-1:0] didx_q, didx_d;
  logic              dissued_q, dissued_d, out_valid_q, out_valid_d;
  logic              out_sat_q, out_sat_d, out_last_q, out_last_d, drain_done, bank_busy;
  logic [DWIDTH-1:0] out_data_q, out_data_d;

  // Pass control: stall rules, idx/len latching at idx 0, bank advance, stage-1 capture with registered read
  always_comb begin
    at_idx0    = (idx_q == '0);
    p_len      = at_idx0 ? cfg_len_m1 : len_q;
    p_sat      = at_idx0 ? cfg_sat    : sat_q;
    p_first    = at_idx0 ? in_first   : first_q;
    p_last     = at_idx0 ? in_last    : last_q;
    in_ready   = rdy_en_q &
                 !(at_idx0 & ((in_first & (bank_st_q[acc_bank_q] != B_FREE)) |
                              (!in_first & (bank_st_q[acc_bank_q] != B_ACC))));
    accept     = in_valid & in_ready;
    pass_end   = (idx_q == p_len);
    start_tile = accept & at_idx0 & in_first;
    idx_d      = idx_q;
    len_d      = len_q;
    sat_d      = sat_q;
    first_d    = first_q;
    last_d     = last_q;
    acc_bank_d = acc_bank_q;
    if (accept) begin
      len_d   = p_len;
      sat_d   = p_sat;
      first_d = p_first;
      last_d  = p_last;
      if (pass_end) begin
        idx_d = '0;
        if (p_last) acc_bank_d = (acc_bank_q == BW'(NBANK-1)) ? '0 : acc_bank_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    s1_valid_d = accept;
    s1_bank_d  = acc_bank_q;
    s1_idx_d   = idx_q;
    s1_data_d  = in_data;
    s1_sat_d   = p_sat;
    s1_first_d = p_first;
    s1_fin_d   = p_last & pass_end;
    rd_data_d  = mem_q[acc_bank_q][idx_q];
    rd_flag_d  = flag_q[acc_bank_q][idx_q];
  end

  // Add stage: forward the previous beat's write when it hits the same entry, then add and clamp
  always_comb begin
    fwd      = s2_valid_q && (s2_bank_q == s1_bank_q) && (s2_idx_q == s1_idx_q);
    old_val  = s1_first_q ? '0 : (fwd ? s2_sum_q : rd_data_q);
    old_flag = s1_first_q ? 1'b0 : (fwd ? s2_flag_q : rd_flag_q);
    ext_val  = DWIDTH'($signed(s1_data_q));
    wide     = {old_val[DWIDTH-1], old_val} + {ext_val[DWIDTH-1], ext_val};
    ovf      = wide[DWIDTH] != wide[DWIDTH-1];
    sum_val  = wide[DWIDTH-1:0];
    sat_now  = 1'b0;
    if (s1_sat_q && ovf) begin
      sat_now = 1'b1;
      sum_val = wide[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    end
    flag_new   = old_flag | sat_now;
    s2_valid_d = s1_valid_q;
    s2_bank_d  = s1_bank_q;
    s2_idx_d   = s1_idx_q;
    s2_sum_d   = sum_val;
    s2_flag_d  = flag_new;
  end

  // Drain: registered read of drain_bank into a skid-free output register, one entry per handshake
  always_comb begin
    drain_bank_d = drain_bank_q;
    didx_d       = didx_q;
    dissued_d    = dissued_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    out_last_d   = out_last_q;
    out_bank_d   = out_bank_q;
    drain_done   = out_valid_q & out_ready & out_last_q;
    if (out_valid_q & out_ready) out_valid_d = 1'b0;
    if (drain_done) begin
      drain_bank_d = (drain_bank_q == BW'(NBANK-1)) ? '0 : drain_bank_q + 1'b1;
      didx_d       = '0;
      dissued_d    = 1'b0;
    end else if ((bank_st_q[drain_bank_q] == B_DRAIN) && !dissued_q && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[drain_bank_q][didx_q];
      out_sat_d   = flag_q[drain_bank_q][didx_q];
      out_last_d  = (didx_q == bank_len_q[drain_bank_q]);
      out_bank_d  = drain_bank_q;
      didx_d      = didx_q + 1'b1;
      dissued_d   = (didx_q == bank_len_q[drain_bank_q]);
    end
  end

  // Per-bank lifecycle FREE -> ACC -> DRAIN -> FREE; the three events always target distinct banks
  always_comb begin
    bank_busy = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      bank_st_d[b]  = bank_st_q[b];
      bank_len_d[b] = bank_len_q[b];
      if (start_tile && (acc_bank_q == BW'(b))) begin
        bank_st_d[b]  = B_ACC;
        bank_len_d[b] = cfg_len_m1;
      end
      if (s1_valid_q && s1_fin_q && (s1_bank_q == BW'(b))) bank_st_d[b] = B_DRAIN;
      if (drain_done && (drain_bank_q == BW'(b))) bank_st_d[b] = B_FREE;
      if (bank_st_q[b] != B_FREE) bank_busy = 1'b1;
    end
  end

  // Control and pipeline registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < NBANK; b++) begin
        bank_st_q[b]  <= B_FREE;
        bank_len_q[b] <= '0;
      end
      acc_bank_q <= '0;  idx_q <= '0;  len_q <= '0;  sat_q <= 1'b0;
      first_q <= 1'b0;   last_q <= 1'b0;  rdy_en_q <= 1'b0;
      s1_valid_q <= 1'b0; s1_bank_q <= '0; s1_idx_q <= '0; s1_data_q <= '0;
      s1_sat_q <= 1'b0;  s1_first_q <= 1'b0; s1_fin_q <= 1'b0;
      rd_data_q <= '0;   rd_flag_q <= 1'b0;
      s2_valid_q <= 1'b0; s2_bank_q <= '0; s2_idx_q <= '0; s2_sum_q <= '0; s2_flag_q <= 1'b0;
      drain_bank_q <= '0; didx_q <= '0; dissued_q <= 1'b0;
      out_valid_q <= 1'b0; out_data_q <= '0; out_sat_q <= 1'b0; out_last_q <= 1'b0; out_bank_q <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        bank_st_q[b]  <= bank_st_d[b];
        bank_len_q[b] <= bank_len_d[b];
      end
      acc_bank_q <= acc_bank_d;  idx_q <= idx_d;  len_q <= len_d;  sat_q <= sat_d;
      first_q <= first_d;  last_q <= last_d;  rdy_en_q <= 1'b1;
      s1_valid_q <= s1_valid_d; s1_bank_q <= s1_bank_d; s1_idx_q <= s1_idx_d; s1_data_q <= s1_data_d;
      s1_sat_q <= s1_sat_d;  s1_first_q <= s1_first_d; s1_fin_q <= s1_fin_d;
      rd_data_q <= rd_data_d; rd_flag_q <= rd_flag_d;
      s2_valid_q <= s2_valid_d; s2_bank_q <= s2_bank_d; s2_idx_q <= s2_idx_d;
      s2_sum_q <= s2_sum_d;  s2_flag_q <= s2_flag_d;
      drain_bank_q <= drain_bank_d; didx_q <= didx_d; dissued_q <= dissued_d;
      out_valid_q <= out_valid_d; out_data_q <= out_data_d; out_sat_q <= out_sat_d;
      out_last_q <= out_last_d;  out_bank_q <= out_bank_d;
    end
  end

  // Accumulator storage: write-back of the add stage; contents are meaningless until a first pass rewrites them
  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      mem_q[s1_bank_q][s1_idx_q]  <= sum_val;
      flag_q[s1_bank_q][s1_idx_q] <= flag_new;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_last  = out_last_q;
  assign out_bank  = out_bank_q;
  assign busy      = bank_busy | s1_valid_q;

endmodule

// File: tb/tb_psum_bank_acc.sv
// tb/tb_psum_bank_acc.sv - scoreboard bench for psum_bank_acc with a pass-level arithmetic model
module tb_psum_bank_acc;
  localparam int DW = 16, PW = 16, AW = 4, NB = 2;
  localparam int MAXV = 32767, MINV = -32768;

  logic          clk = 1'b0, rstn = 1'b0;
  logic [AW-1:0] cfg_len_m1 = '0;
  logic          cfg_sat = 1'b0, in_valid = 1'b0, in_ready, in_first = 1'b1, in_last = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b0, out_sat, out_last, busy;
  logic [DW-1:0] out_data;
  logic          out_bank;

  psum_bank_acc #(.DWIDTH(DW), .PE_DWIDTH(PW), .AWIDTH(AW), .NBANK(NB)) dut (
    .clk(clk), .rstn(rstn), .cfg_len_m1(cfg_len_m1), .cfg_sat(cfg_sat),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_last(out_last), .out_bank(out_bank), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int data; bit sat; bit last; int bank; } exp_t;
  exp_t expq[$];
  int   checks = 0, failures = 0, cyc = 0, tile_cnt = 0, or_mode = 0;
  int   stim_d [8][16];
  bit   stim_sat [8];
  int   hs_cyc [NB];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Expected drain contents: serial accumulation pass by pass, clamp or wrap on 16-bit overflow
  task automatic push_expected(input int np, input int lm1, input int bank);
    exp_t e;
    int acc, s;
    bit fl;
    for (int i = 0; i <= lm1; i++) begin
      acc = 0;
      fl  = 1'b0;
      for (int p = 0; p < np; p++) begin
        s = acc + stim_d[p][i];
        if (s > MAXV || s < MINV) begin
          if (stim_sat[p]) begin
            s  = (s > MAXV) ? MAXV : MINV;
            fl = 1'b1;
          end else begin
            s = (s > MAXV) ? s - 65536 : s + 65536;
          end
        end
        acc = s;
      end
      e.data = acc; e.sat = fl; e.last = (i == lm1); e.bank = bank;
      expq.push_back(e);
    end
  endtask

  task automatic idle_cycle();
    in_valid   = 1'b0;
    in_first   = 1'($urandom);
    in_last    = 1'($urandom);
    cfg_sat    = 1'($urandom);
    cfg_len_m1 = AW'($urandom);
    @(posedge clk); #2;
  endtask

  task automatic send_beat(input int d, input bit idx0, input bit f, input bit l, input bit s,
                           input int lm1, output int st, output int acyc);
    in_valid = 1'b1;
    in_data  = PW'(d);
    if (idx0) begin
      in_first = f; in_last = l; cfg_sat = s; cfg_len_m1 = AW'(lm1);
    end else begin
      in_first = 1'($urandom); in_last = 1'($urandom);
      cfg_sat = 1'($urandom); cfg_len_m1 = AW'($urandom);
    end
    st = 0;
    acyc = -1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        acyc = cyc;
        break;
      end
      st++;
      if (st > 3000) begin
        checks++; failures++;
        $display("FAIL in_ready_timeout actual=%0d required=%0d", in_ready, 1);
        finish_tb();
      end
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic run_tile(input int np, input int lm1, input bit gaps, input int abort_pass,
                          output int stalls, output int facc);
    int st, ac, bank;
    bank   = tile_cnt % NB;
    stalls = 0;
    facc   = -1;
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i <= lm1; i++) begin
        if (p == abort_pass && i == 1) return;
        if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
        send_beat(stim_d[p][i], i == 0, p == 0, p == np - 1, stim_sat[p], lm1, st, ac);
        stalls += st;
        if (facc < 0) facc = ac;
      end
    end
    push_expected(np, lm1, bank);
    tile_cnt++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((expq.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_complete", expq.size(), 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #2;
  endtask

  // Downstream ready pattern: 0 hold, 1 always, 2 toggle, 3 random
  initial forever begin
    @(posedge clk); #2;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom);
    endcase
  end

  // Monitor: every presented entry must equal the scoreboard head; pop on handshake
  initial begin
    exp_t e;
    bit prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("out_valid_held", out_valid, 1);
        if (out_valid) begin
          if (expq.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 0);
          end else begin
            e = expq[0];
            chk("out_data", $signed(out_data), e.data);
            chk("out_sat", out_sat, e.sat);
            chk("out_last", out_last, e.last);
            chk("out_bank", out_bank, e.bank);
            if (out_ready) begin
              if (e.last) hs_cyc[e.bank] = cyc;
              void'(expq.pop_front());
            end
          end
        end
        prev_stall = out_valid & ~out_ready;
      end
    end
  end

  initial begin
    int st, fa, fa_c, np, lm1, a_bank;
    bit big;
    logic signed [15:0] r;

    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_bank", out_bank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(negedge clk);
    chk("in_ready_before_first_clk", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_first_clk", in_ready, 1);
    @(posedge clk); #2;

    // Three passes into bank 0
    or_mode = 1;
    for (int i = 0; i < 4; i++) begin
      stim_d[0][i] = i + 1;
      stim_d[1][i] = 10 * (i + 1);
      stim_d[2][i] = -1;
    end
    for (int p = 0; p < 3; p++) stim_sat[p] = 1'b0;
    run_tile(3, 3, 1'b0, -1, st, fa);
    wait_idle();

    // Ping-pong: A drains under 1010 backpressure while B accumulates without stalling
    or_mode = 2;
    for (int p = 0; p < 2; p++) begin
      stim_sat[p] = 1'b0;
      for (int i = 0; i < 16; i++) stim_d[p][i] = $urandom_range(0, 2000) - 1000;
    end
    run_tile(2, 15, 1'b0, -1, st, fa);
    for (int i = 0; i < 16; i++) stim_d[1][i] = $urandom_range(0, 2000) - 1000;
    run_tile(2, 15, 1'b0, -1, st, fa);
    chk("pingpong_no_stall", st, 0);
    wait_idle();

    // All banks in DRAIN: third tile stalls until the oldest bank hands off its last entry
    or_mode = 0;
    a_bank = tile_cnt % NB;
    run_tile(2, 5, 1'b0, -1, st, fa);
    run_tile(1, 3, 1'b0, -1, st, fa);
    fork
      run_tile(2, 2, 1'b0, -1, st, fa_c);
      begin
        repeat (6) @(negedge clk);
        chk("all_full_in_ready", in_ready, 0);
        chk("all_full_busy", busy, 1);
        @(posedge clk); #2;
        or_mode = 1;
      end
    join
    chk("all_full_accept_cycle", fa_c, hs_cyc[a_bank] + 1);
    wait_idle();

    // Saturating and wrapping overflow at both rails
    for (int m = 0; m < 2; m++) begin
      stim_d[0][0] = 32767;  stim_d[1][0] = 1;
      stim_d[0][1] = -32768; stim_d[1][1] = -1;
      stim_sat[0] = (m == 0); stim_sat[1] = (m == 0);
      run_tile(2, 1, 1'b0, -1, st, fa);
      wait_idle();
    end

    // Single-entry passes back to back: every read depends on the previous write
    for (int p = 0; p < 5; p++) begin
      stim_d[p][0] = p + 1;
      stim_sat[p]  = 1'b0;
    end
    run_tile(5, 0, 1'b0, -1, st, fa);
    wait_idle();

    // Reset during the second pass, then a fresh tile must land in bank 0
    for (int p = 0; p < 3; p++) begin
      stim_sat[p] = 1'b0;
      for (int i = 0; i < 4; i++) stim_d[p][i] = $urandom_range(0, 100);
    end
    run_tile(3, 3, 1'b0, 1, st, fa);
    @(negedge clk);
    chk("busy_mid_tile", busy, 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #2;
    rstn = 1'b1;
    tile_cnt = 0;
    @(posedge clk); #2;
    run_tile(3, 3, 1'b0, -1, st, fa);
    wait_idle();

    // Random tiles: lengths, pass counts, saturation mode, gaps and backpressure
    or_mode = 3;
    for (int t = 0; t < 24; t++) begin
      np  = $urandom_range(1, 4);
      lm1 = (t % 4 == 0) ? $urandom_range(0, 1) : $urandom_range(0, 15);
      big = 1'($urandom);
      for (int p = 0; p < np; p++) begin
        stim_sat[p] = 1'($urandom);
        for (int i = 0; i <= lm1; i++) begin
          r = 16'($urandom);
          stim_d[p][i] = big ? int'(r) : $urandom_range(0, 200) - 100;
        end
      end
      run_tile(np, lm1, 1'b1, -1, st, fa);
    end
    or_mode = 1;
    wait_idle();

    finish_tb();
  end
endmodule
